// File: rtl/thcompctrl.sv
// rtl/thcompctrl.sv - sequencer for the shared threshold comparator in the sync chain
//
// Parameters:
//   MSB      operand MSB (operand width MSB+1), same as the comparator
//   HITS     consecutive hits needed to declare sync (1..15)
//   CNT_W    sample counter / index width
//   MAX_SAMP samples per run before timeout (1..2^CNT_W)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   thcompctrl_start/_abort     run start pulse / abort current run
//   thcompctrl_threshold        threshold, captured on an accepted start
//   thcompctrl_metric_*         metric sample stream (valid/data/ready)
//   thcompctrl_thcomp_op0/op1   registered comparator operands (metric, threshold)
//   thcompctrl_thcomp_start     one-cycle comparator start
//   thcomp_thcompctrl_finish    comparator finish strobe
//   thcomp_thcompctrl_data      comparator result (1 = op0 > op1)
//   thcompctrl_busy             run in progress
//   thcompctrl_sync_found       one-cycle pulse, sync declared
//   thcompctrl_sync_index       0-based index of the sample completing the hit run
//   thcompctrl_timeout          one-cycle pulse, sample budget exhausted
module thcompctrl #(
   parameter int MSB      = 15,
   parameter int HITS     = 3,
   parameter int CNT_W    = 10,
   parameter int MAX_SAMP = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             thcompctrl_start,
   input  logic             thcompctrl_abort,
   input  logic [MSB:0]     thcompctrl_threshold,
   input  logic             thcompctrl_metric_valid,
   input  logic [MSB:0]     thcompctrl_metric_data,
   output logic             thcompctrl_metric_ready,
   output logic [MSB:0]     thcompctrl_thcomp_op0,
   output logic [MSB:0]     thcompctrl_thcomp_op1,
   output logic             thcompctrl_thcomp_start,
   input  logic             thcomp_thcompctrl_finish,
   input  logic             thcomp_thcompctrl_data,
   output logic             thcompctrl_busy,
   output logic             thcompctrl_sync_found,
   output logic [CNT_W-1:0] thcompctrl_sync_index,
   output logic             thcompctrl_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_CMPW  = 2'd3
   } state_t;

   localparam logic [3:0]       HITS_C    = 4'(HITS);
   localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(MAX_SAMP - 1);

   state_t           state_q, state_d;
   logic [MSB:0]     op0_q, op0_d;
   logic [MSB:0]     op1_q, op1_d;
   logic [3:0]       hit_cnt_q, hit_cnt_d;
   logic [3:0]       hit_next;
   logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
   logic [CNT_W-1:0] sync_index_q, sync_index_d;
   logic             thcomp_start_q, thcomp_start_d;
   logic             sync_found_q, sync_found_d;
   logic             timeout_q, timeout_d;

   always_comb begin
      state_d        = state_q;
      op0_d          = op0_q;
      op1_d          = op1_q;
      hit_cnt_d      = hit_cnt_q;
      samp_cnt_d     = samp_cnt_q;
      sync_index_d   = sync_index_q;
      thcomp_start_d = 1'b0;
      sync_found_d   = 1'b0;
      timeout_d      = 1'b0;
      // Hit count after this result; a miss restarts the run, so hits need
      // not be aligned to sample 0. It never exceeds HITS, so 4 bits suffice.
      hit_next       = thcomp_thcompctrl_data ? (hit_cnt_q + 4'd1) : 4'd0;

      case (state_q)
         S_IDLE: begin
            // Start coinciding with abort is dropped.
            if (thcompctrl_start && !thcompctrl_abort) begin
               op1_d      = thcompctrl_threshold;
               hit_cnt_d  = 4'd0;
               samp_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (thcompctrl_abort) begin
               state_d = S_IDLE;
            end else if (thcompctrl_metric_valid) begin
               op0_d          = thcompctrl_metric_data;
               // Registered so the pulse lines up with the ISSUE cycle.
               thcomp_start_d = 1'b1;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = thcompctrl_abort ? S_IDLE : S_CMPW;
         end
         S_CMPW: begin
            // Abort outranks a simultaneous finish: the result is discarded.
            if (thcompctrl_abort) begin
               state_d = S_IDLE;
            end else if (thcomp_thcompctrl_finish) begin
               hit_cnt_d = hit_next;
               // Sync is tested first so it wins over timeout on the last sample.
               if (hit_next == HITS_C) begin
                  sync_found_d = 1'b1;
                  sync_index_d = samp_cnt_q;
                  state_d      = S_IDLE;
               end else if (samp_cnt_q == LAST_SAMP) begin
                  timeout_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  samp_cnt_d = samp_cnt_q + 1'b1;
                  state_d    = S_WAIT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op0_q          <= '0;
         op1_q          <= '0;
         hit_cnt_q      <= 4'd0;
         samp_cnt_q     <= '0;
         sync_index_q   <= '0;
         thcomp_start_q <= 1'b0;
         sync_found_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         op0_q          <= op0_d;
         op1_q          <= op1_d;
         hit_cnt_q      <= hit_cnt_d;
         samp_cnt_q     <= samp_cnt_d;
         sync_index_q   <= sync_index_d;
         thcomp_start_q <= thcomp_start_d;
         sync_found_q   <= sync_found_d;
         timeout_q      <= timeout_d;
      end
   end

   assign thcompctrl_metric_ready = (state_q == S_WAIT);
   assign thcompctrl_busy         = (state_q != S_IDLE);
   assign thcompctrl_thcomp_op0   = op0_q;
   assign thcompctrl_thcomp_op1   = op1_q;
   assign thcompctrl_thcomp_start = thcomp_start_q;
   assign thcompctrl_sync_found   = sync_found_q;
   assign thcompctrl_sync_index   = sync_index_q;
   assign thcompctrl_timeout      = timeout_q;

endmodule

// File: tb/tb_thcompctrl.sv
// tb/tb_thcompctrl.sv - self-checking bench for thcompctrl with a sample-sequence reference model
module tb_thcompctrl;

   localparam int MAXS  = 6;
   localparam int NHITS = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] threshold = '0;
   logic        valid = 1'b0;
   logic [15:0] mdata = '0;
   logic        ready;
   logic [15:0] op0, op1;
   logic        tstart;
   logic        fin = 1'b0;
   logic        fdata = 1'b0;
   logic        busy;
   logic        sync;
   logic [9:0]  sidx;
   logic        tout;

   int n_checks = 0;
   int n_errors = 0;
   int exp_sidx = 0;
   logic [15:0] met [0:MAXS-1];

   thcompctrl #(.MSB(15), .HITS(NHITS), .CNT_W(10), .MAX_SAMP(MAXS)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .thcompctrl_start         (start),
      .thcompctrl_abort         (abort),
      .thcompctrl_threshold     (threshold),
      .thcompctrl_metric_valid  (valid),
      .thcompctrl_metric_data   (mdata),
      .thcompctrl_metric_ready  (ready),
      .thcompctrl_thcomp_op0    (op0),
      .thcompctrl_thcomp_op1    (op1),
      .thcompctrl_thcomp_start  (tstart),
      .thcomp_thcompctrl_finish (fin),
      .thcomp_thcompctrl_data   (fdata),
      .thcompctrl_busy          (busy),
      .thcompctrl_sync_found    (sync),
      .thcompctrl_sync_index    (sidx),
      .thcompctrl_timeout       (tout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outcome of a whole run from the sample list alone: kind 1 = sync, 2 = timeout.
   function automatic void predict(input logic [15:0] thr, output int kind, output int idx);
      int streak = 0;
      kind = 2;
      idx  = MAXS - 1;
      for (int i = 0; i < MAXS; i++) begin
         streak = (met[i] > thr) ? streak + 1 : 0;
         if (streak == NHITS) begin
            kind = 1;
            idx  = i;
            return;
         end
      end
   endfunction

   // Runs met[] through the DUT; abort_at >= 0 raises abort with that sample's finish.
   task automatic run(input logic [15:0] thr, input int abort_at);
      int kind, idx, lat;
      predict(thr, kind, idx);
      start = 1'b1;
      threshold = thr;
      tick();
      start = 1'b0;
      threshold = 16'($urandom);
      chk("busy_after_start", busy, 1);
      chk("op1_load", op1, thr);
      for (int i = 0; i <= idx; i++) begin
         chk("ready_wait", ready, 1);
         valid = 1'b1;
         mdata = met[i];
         tick();
         valid = 1'b0;
         mdata = 16'($urandom);
         chk("tstart_issue", tstart, 1);
         chk("op0_load", op0, met[i]);
         chk("op1_hold", op1, thr);
         chk("ready_issue", ready, 0);
         tick();
         chk("tstart_len", tstart, 0);
         lat = $urandom_range(0, 2);
         repeat (lat) tick();
         chk("busy_cmpw", busy, 1);
         chk("op0_hold", op0, met[i]);
         fin = 1'b1;
         fdata = (met[i] > thr);
         if (i == abort_at) abort = 1'b1;
         tick();
         fin = 1'b0;
         fdata = 1'b0;
         abort = 1'b0;
         if (i == abort_at) begin
            chk("abort_busy", busy, 0);
            chk("abort_sync", sync, 0);
            chk("abort_timeout", tout, 0);
            chk("abort_sidx", sidx, exp_sidx);
            return;
         end
         if (i == idx) begin
            if (kind == 1) exp_sidx = idx;
            chk("sync_found", sync, (kind == 1));
            chk("timeout", tout, (kind == 2));
            chk("end_busy", busy, 0);
            chk("end_ready", ready, 0);
            chk("sync_index", sidx, exp_sidx);
            tick();
            chk("sync_len", sync, 0);
            chk("timeout_len", tout, 0);
         end else begin
            chk("mid_sync", sync, 0);
            chk("mid_timeout", tout, 0);
            chk("mid_ready", ready, 1);
         end
      end
   endtask

   task automatic load(input int a, input int b, input int c, input int d, input int e, input int f);
      met[0] = 16'(a); met[1] = 16'(b); met[2] = 16'(c);
      met[3] = 16'(d); met[4] = 16'(e); met[5] = 16'(f);
   endtask

   initial begin
      int thr, spread;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      chk("rst_op0", op0, 0);
      chk("rst_op1", op1, 0);
      chk("rst_sidx", sidx, 0);
      chk("rst_pulses", {tstart, sync, tout}, 0);

      load(101, 150, 200, 0, 0, 0);       run(16'd100, -1);  // sync at 2
      load(101, 100, 120, 130, 140, 0);   run(16'd100, -1);  // equal is a miss, sync at 4
      load(0, 0, 0, 0, 0, 0);             run(16'd50, -1);   // timeout
      load(0, 0, 0, 200, 200, 200);       run(16'd50, -1);   // sync on last sample beats timeout
      load(101, 150, 200, 0, 0, 0);       run(16'd100, 2);   // abort with the 3rd finish
      load(8, 9, 10, 0, 0, 0);            run(16'd7, -1);    // counters cleared by new start

      for (int r = 0; r < 30; r++) begin
         thr = $urandom_range(10, 60000);
         spread = $urandom_range(3, 6);
         for (int i = 0; i < MAXS; i++) met[i] = 16'(thr - 1 + $urandom_range(0, spread));
         run(16'(thr), -1);
      end

      // Reset during CMPW drops the run and clears everything.
      start = 1'b1; threshold = 16'd20; tick();
      start = 1'b0; valid = 1'b1; mdata = 16'd30; tick();
      valid = 1'b0; tick();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; tick();
      rst = 1'b0;
      exp_sidx = 0;
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_op0", op0, 0);
      chk("midrst_op1", op1, 0);
      chk("midrst_sidx", sidx, exp_sidx);
      chk("midrst_pulses", {tstart, sync, tout}, 0);

      // Start while busy is ignored.
      start = 1'b1; threshold = 16'd20; tick();
      start = 1'b1; threshold = 16'd99; tick();
      start = 1'b0;
      chk("busy_start_op1", op1, 20);
      chk("busy_start_ready", ready, 1);
      abort = 1'b1; tick();
      abort = 1'b0;
      chk("abort_wait_busy", busy, 0);
      chk("abort_wait_op1", op1, 20);

      // Start and abort together in IDLE.
      start = 1'b1; abort = 1'b1; threshold = 16'd55; tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_op1", op1, 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
